// File: rtl/dpram_burst_reader.sv
// dpram_burst_reader
// Read-side master for the dual-port RAM. A start command latches a base
// address and a length, then consecutive words are read from the RAM read
// port and presented as a valid/ready stream with a last-beat flag. A
// 2-entry output FIFO hides the RAM's one-cycle read latency and absorbs
// downstream backpressure while still sustaining one word per cycle.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst_n      in   synchronous active-low reset
//   start      in   command strobe, accepted only while not busy
//   base_addr  in   first burst address (sampled with start)
//   len_m1     in   burst length minus one (sampled with start)
//   busy       out  burst in progress
//   done       out  one-cycle pulse after the last beat transfers
//   read_en    out  RAM read enable
//   RAdddr     out  RAM read address (holds its last value when idle)
//   ram_rdata  in   RAM read data, valid the cycle after read_en
//   m_valid    out  stream beat valid
//   m_ready    in   stream consumer ready
//   m_data     out  stream data (FIFO head)
//   m_last     out  final beat of the burst, qualified by m_valid
module dpram_burst_reader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] len_m1,
  output logic                  busy,
  output logic                  done,
  output logic                  read_en,
  output logic [ADDR_WIDTH-1:0] RAdddr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic [ADDR_WIDTH-1:0] raddr_q;
  // One extra bit so a full 2^ADDR_WIDTH burst does not alias back to zero.
  logic [ADDR_WIDTH:0]   issued_q, issued_d;
  logic [ADDR_WIDTH:0]   beat_q, beat_d;
  logic                  inflight_q;
  logic [1:0]            count_q, count_d;
  logic                  wrPtr_q, rdPtr_q;
  logic [DATA_WIDTH-1:0] fifoMem_q [2];
  logic                  done_q, done_d;

  logic                  push;
  logic                  pop;
  logic                  issue;
  logic                  lastBeat;
  logic [ADDR_WIDTH:0]   lenExt;
  logic [2:0]            occupancy;

  assign lenExt    = {1'b0, len_q};
  assign push      = inflight_q;
  assign m_valid   = (count_q != 2'd0);
  assign m_data    = fifoMem_q[rdPtr_q];
  assign m_last    = m_valid && (beat_q == lenExt);
  assign pop       = m_valid && m_ready;
  assign lastBeat  = pop && (beat_q == lenExt);
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q};

  // Credit rule: a new read may only issue if, after this cycle's pop, the
  // FIFO entries plus the read already in flight leave room for its data.
  // This is where read_en picks up its combinational path from m_ready.
  assign issue   = (state_q == RUN) && (issued_q <= lenExt) &&
                   (occupancy <= (3'd1 + {2'b00, pop}));
  assign read_en = issue;
  assign RAdddr  = issue ? (base_q + issued_q[ADDR_WIDTH-1:0]) : raddr_q;
  assign busy    = (state_q == RUN);
  assign done    = done_q;

  // Next-state logic: command acceptance in IDLE, counter advance in RUN,
  // and the return to IDLE on the handshake of the final beat.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    issued_d = issued_q;
    beat_d   = beat_q;
    done_d   = 1'b0;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d   = base_addr;
          len_d    = len_m1;
          issued_d = '0;
          beat_d   = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (issue) begin
          issued_d = issued_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
        end
        if (pop) begin
          beat_d = beat_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
        end
        if (lastBeat) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and FIFO storage. Reset also discards any read in
  // flight and clears the FIFO contents so m_data reads back as zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      base_q       <= '0;
      len_q        <= '0;
      raddr_q      <= '0;
      issued_q     <= '0;
      beat_q       <= '0;
      inflight_q   <= 1'b0;
      count_q      <= 2'd0;
      wrPtr_q      <= 1'b0;
      rdPtr_q      <= 1'b0;
      fifoMem_q[0] <= '0;
      fifoMem_q[1] <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      raddr_q    <= RAdddr;
      issued_q   <= issued_d;
      beat_q     <= beat_d;
      inflight_q <= issue;
      count_q    <= count_d;
      done_q     <= done_d;
      if (push) begin
        fifoMem_q[wrPtr_q] <= ram_rdata;
      end
      wrPtr_q <= wrPtr_q ^ push;
      rdPtr_q <= rdPtr_q ^ pop;
    end
  end

endmodule

// File: tb/tb_dpram_burst_reader.sv
// tb_dpram_burst_reader
// Self-checking bench for dpram_burst_reader. Each accepted command pushes
// its expected read addresses and beats (computed directly from RAM contents
// and burst arithmetic) into queues; an independent monitor pops and
// compares whenever the DUT issues a read or transfers a beat.
module tb_dpram_burst_reader;

  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] len_m1;
  logic          busy;
  logic          done;
  logic          read_en;
  logic [AW-1:0] RAdddr;
  logic [DW-1:0] ram_rdata;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            idx;
    bit            timed;
  } beat_t;

  logic [DW-1:0] mem [256];
  beat_t         expQ[$];
  logic [AW-1:0] addrQ[$];
  beat_t         curBeat;
  logic [AW-1:0] curAddr;

  int   checks = 0;
  int   failures = 0;
  int   cycleCnt = 0;
  int   startCycle = 0;
  int   beatsSeen = 0;
  int   readEnCount = 0;
  int   outstanding = 0;
  bit   lastXferPrev = 1'b0;
  bit   resetSeen = 1'b0;
  bit   prevStall = 1'b0;
  bit   popNow;
  bit   randReady = 1'b0;
  logic [DW-1:0] prevData;
  logic          prevLast;

  dpram_burst_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .len_m1    (len_m1),
    .busy      (busy),
    .done      (done),
    .read_en   (read_en),
    .RAdddr    (RAdddr),
    .ram_rdata (ram_rdata),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Cycle counter used to timestamp starts and beats.
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Behavioural RAM read port: registered read, data one cycle after read_en.
  always @(posedge clk) begin
    if (read_en) ram_rdata <= mem[RAdddr];
  end

  // Randomised consumer backpressure, active only while randReady is set.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (randReady) m_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: samples mid-cycle and checks addresses, beats, timing, stall
  // stability, the issue credit limit, the done pulse and reset values.
  always @(negedge clk) begin
    if (!rst_n) begin
      expQ.delete();
      addrQ.delete();
      outstanding  = 0;
      lastXferPrev = 1'b0;
      prevStall    = 1'b0;
      resetSeen    = 1'b1;
    end else begin
      if (resetSeen) begin
        resetSeen = 1'b0;
        checks++;
        if ({busy, done, read_en, m_valid, m_last} !== 5'b0 || RAdddr !== '0 || m_data !== '0) begin
          failures++;
          $display("[TB] FAIL resetOutputs actual busy=%0b done=%0b rd=%0b v=%0b last=%0b addr=%0h data=%0h required all zero",
                   busy, done, read_en, m_valid, m_last, RAdddr, m_data);
        end
      end
      popNow = m_valid && m_ready;
      if (done || lastXferPrev) begin
        checks++;
        if (done !== lastXferPrev) begin
          failures++;
          $display("[TB] FAIL donePulse actual=%0b required=%0b at cycle %0d", done, lastXferPrev, cycleCnt);
        end
      end
      if (start && !busy) startCycle = cycleCnt;
      if (prevStall) begin
        checks++;
        if (!m_valid || m_data !== prevData || m_last !== prevLast) begin
          failures++;
          $display("[TB] FAIL stallStable actual v=%0b data=%0h last=%0b required v=1 data=%0h last=%0b",
                   m_valid, m_data, m_last, prevData, prevLast);
        end
      end
      if (read_en) begin
        readEnCount++;
        checks++;
        if (addrQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL readAddr actual=%0h required no read", RAdddr);
        end else begin
          curAddr = addrQ.pop_front();
          if (RAdddr !== curAddr) begin
            failures++;
            $display("[TB] FAIL readAddr actual=%0h required=%0h", RAdddr, curAddr);
          end
        end
        checks++;
        if (outstanding - int'(popNow) > 1) begin
          failures++;
          $display("[TB] FAIL issueCredit actual held=%0d pop=%0b required held-pop<=1", outstanding, popNow);
        end
      end
      lastXferPrev = 1'b0;
      if (popNow) begin
        checks++;
        if (expQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL beat actual data=%0h required no beat", m_data);
        end else begin
          curBeat = expQ.pop_front();
          if (m_data !== curBeat.data || m_last !== curBeat.last) begin
            failures++;
            $display("[TB] FAIL beat%0d actual data=%0h last=%0b required data=%0h last=%0b",
                     curBeat.idx, m_data, m_last, curBeat.data, curBeat.last);
          end
          if (curBeat.timed) begin
            checks++;
            if (cycleCnt != startCycle + 3 + curBeat.idx) begin
              failures++;
              $display("[TB] FAIL beatTiming%0d actual=%0d required=%0d", curBeat.idx,
                       cycleCnt - startCycle, 3 + curBeat.idx);
            end
          end
          lastXferPrev = curBeat.last;
        end
        beatsSeen++;
      end
      outstanding = outstanding + int'(read_en) - int'(popNow);
      prevStall = m_valid && !m_ready;
      prevData  = m_data;
      prevLast  = m_last;
    end
  end

  // Generic scalar comparison used by the directed checks.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Issue a command and record the expected addresses and beats for it.
  task automatic applyStimulus(input logic [AW-1:0] base, input logic [AW-1:0] lenm1, input bit timed);
    beat_t         b;
    logic [AW-1:0] a;
    start     = 1'b1;
    base_addr = base;
    len_m1    = lenm1;
    for (int i = 0; i <= int'(lenm1); i++) begin
      a       = base + AW'(i);
      b.data  = mem[a];
      b.last  = (i == int'(lenm1));
      b.idx   = i;
      b.timed = timed;
      addrQ.push_back(a);
      expQ.push_back(b);
    end
    @(posedge clk);
    #1;
    start     = 1'b0;
    base_addr = AW'($urandom);
    len_m1    = AW'($urandom);
  endtask

  // Wait (bounded) until the done pulse is visible.
  task automatic waitDone(input int limit);
    int n = 0;
    while (!done && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("[TB] FAIL doneTimeout actual=no done required done within %0d cycles", limit);
    end
  endtask

  // Main stimulus sequence.
  initial begin
    int b0;
    int n;
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    len_m1    = '0;
    m_ready   = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = DW'(a) ^ 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("resetBusy", 32'(busy), 32'd0);
    checkOutput("resetValid", 32'(m_valid), 32'd0);
    checkOutput("resetReadEn", 32'(read_en), 32'd0);

    // Basic 4-word burst with the consumer always ready.
    m_ready     = 1'b1;
    readEnCount = 0;
    applyStimulus(8'h10, 8'd3, 1'b1);
    waitDone(50);
    checkOutput("readEnPulses", 32'(readEnCount), 32'd4);

    // New command in the done cycle, wrapping past the top of the RAM.
    applyStimulus(8'hFE, 8'd3, 1'b1);
    waitDone(50);

    // Single-beat burst.
    applyStimulus(8'h33, 8'd0, 1'b1);
    waitDone(50);

    // start while busy must be ignored.
    applyStimulus(8'h40, 8'd5, 1'b1);
    start     = 1'b1;
    base_addr = 8'h90;
    len_m1    = 8'h20;
    checkOutput("busyDuringBurst", 32'(busy), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(50);

    // Full-size 256-word burst.
    applyStimulus(8'h80, 8'hFF, 1'b1);
    waitDone(400);

    // Randomised backpressure over random RAM contents and bursts.
    for (int a = 0; a < 256; a++) mem[a] = DW'($urandom);
    randReady = 1'b1;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(AW'($urandom), (k == 0) ? 8'd7 : AW'($urandom_range(0, 15)), 1'b0);
      waitDone(300);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    randReady = 1'b0;
    @(posedge clk);
    #1;
    m_ready = 1'b1;

    // Reset in the middle of a burst after two beats.
    b0 = beatsSeen;
    applyStimulus(8'h20, 8'd7, 1'b0);
    n = 0;
    while (beatsSeen < b0 + 2 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("beatsBeforeReset", 32'(beatsSeen - b0), 32'd2);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("busyAfterReset", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(8'h55, 8'd5, 1'b1);
    waitDone(50);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);
    checkOutput("addrQueueEmpty", 32'(addrQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
